// File: rtl/nn_pkg.sv
// Shared definitions for the network weight memory loader: index width,
// loader state encoding and the write-mode constant.
package nn_pkg;

  localparam int   ADDR_W       = 8;
  localparam logic WMODE_WEIGHT = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_WAIT    = 3'd3,
    S_CHECK   = 3'd4,
    S_FIN     = 3'd5
  } state_e;

endpackage

// File: rtl/byte_packer.sv
// Shifts host bytes into a sizew-bit word, little-endian (first byte lands in bits [7:0]).
// last_o flags that the byte currently offered completes the word.
module byte_packer #(
  parameter int sizew = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [7:0]       byte_i,
  output logic [sizew-1:0] word_o,
  output logic             last_o
);

  localparam int NB = sizew / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0]    cnt_q;
  logic [sizew-1:0] word_q;

  assign last_o = (cnt_q == CW'(NB - 1));
  assign word_o = word_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (en_i) begin
      // Each new byte enters at the top, so after NB bytes the first sits at the bottom.
      word_q <= (word_q >> 8) | (sizew'(byte_i) << (sizew - 8));
      cnt_q  <= last_o ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/weight_loader.sv
// Loads weight/bias words from a host byte stream into the network memory, layer -> neuron -> input.
// Optional CHECKSUM_EN: a trailing byte must bring the 8-bit sum of all data bytes to zero, else err.
module weight_loader
  import nn_pkg::*;
#(
  parameter int maxl  = 5,
  parameter int maxn  = 16,
  parameter int maxin = 33,
  parameter int sizew = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] wlayer,
  output logic [ADDR_W-1:0] wn,
  output logic [ADDR_W-1:0] win,
  output logic              wmode,
  output logic              ws,
  output logic [sizew-1:0]  wdata,
  input  logic              wf,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       wcount
);

  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(maxl - 1);
  localparam logic [ADDR_W-1:0] LAST_N  = ADDR_W'(maxn - 1);
  localparam logic [ADDR_W-1:0] LAST_IN = ADDR_W'(maxin - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wlayer_q, wlayer_d, wn_q, wn_d, win_q, win_d;
  logic [15:0]       wcount_q, wcount_d;
  logic              err_q, err_d, wmode_q, wmode_d;
  logic              take, pk_en, pk_clr, pk_last, last_word;

  assign take      = s_valid & s_ready;
  assign last_word = (wlayer_q == LAST_L) && (wn_q == LAST_N) && (win_q == LAST_IN);

  byte_packer #(.sizew(sizew)) u_packer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (pk_clr),
    .en_i   (pk_en),
    .byte_i (s_data),
    .word_o (wdata),
    .last_o (pk_last)
  );

`ifdef CHECKSUM_EN
  logic [7:0] csum_q, csum_d, csum_sum;
  assign csum_sum = csum_q + s_data;

  always_ff @(posedge clk) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wlayer_q <= '0;
      wn_q     <= '0;
      win_q    <= '0;
      wcount_q <= '0;
      err_q    <= 1'b0;
      wmode_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wlayer_q <= wlayer_d;
      wn_q     <= wn_d;
      win_q    <= win_d;
      wcount_q <= wcount_d;
      err_q    <= err_d;
      wmode_q  <= wmode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wlayer_d = wlayer_q;
    wn_d     = wn_q;
    win_d    = win_q;
    wcount_d = wcount_q;
    err_d    = err_q;
    wmode_d  = wmode_q;
    s_ready  = 1'b0;
    ws       = 1'b0;
    done     = 1'b0;
    pk_en    = 1'b0;
    pk_clr   = 1'b0;
`ifdef CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          wlayer_d = '0;
          wn_d     = '0;
          win_d    = '0;
          wcount_d = '0;
          err_d    = 1'b0;
          wmode_d  = WMODE_WEIGHT;
          pk_clr   = 1'b1;
`ifdef CHECKSUM_EN
          csum_d   = '0;
`endif
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        s_ready = 1'b1;
        if (take) begin
          pk_en = 1'b1;
`ifdef CHECKSUM_EN
          csum_d = csum_sum;
`endif
          if (pk_last) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        ws      = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wf) begin
          wcount_d = wcount_q + 16'd1;
          if (win_q == LAST_IN) begin
            win_d = '0;
            if (wn_q == LAST_N) begin
              wn_d     = '0;
              wlayer_d = wlayer_q + ADDR_W'(1);
            end else begin
              wn_d = wn_q + ADDR_W'(1);
            end
          end else begin
            win_d = win_q + ADDR_W'(1);
          end
`ifdef CHECKSUM_EN
          if (last_word) state_d = S_CHECK;
`else
          if (last_word) state_d = S_FIN;
`endif
          else           state_d = S_COLLECT;
        end
      end
`ifdef CHECKSUM_EN
      S_CHECK: begin
        s_ready = 1'b1;
        if (take) begin
          if (csum_sum != 8'd0) err_d = 1'b1;
          state_d = S_FIN;
        end
      end
`endif
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign wlayer = wlayer_q;
  assign wn     = wn_q;
  assign win    = win_q;
  assign wmode  = wmode_q;
  assign err    = err_q;
  assign wcount = wcount_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader with a 2x2x3 network of 32-bit words.
// Define CHECKSUM_EN on both bench and RTL to exercise the trailing checksum byte.
module tb_weight_loader;

  localparam int ML = 2, MN = 2, MI = 3, SW = 32;
  localparam int NW = ML * MN * MI;
  localparam int NBYTES = NW * (SW / 8);

  logic          clk = 1'b0;
  logic          rst, start, s_valid, s_ready, wmode, ws, wf, busy, done, err;
  logic [7:0]    s_data, wlayer, wn, win;
  logic [SW-1:0] wdata;
  logic [15:0]   wcount;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  weight_loader #(.maxl(ML), .maxn(MN), .maxin(MI), .sizew(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wlayer(wlayer), .wn(wn), .win(win), .wmode(wmode), .ws(ws), .wdata(wdata), .wf(wf),
    .busy(busy), .done(done), .err(err), .wcount(wcount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input int i);
    logic [31:0] first;
    first = 32'h1234_5678;
    if (i < 4) return first[8*i +: 8];
    return 8'(i * 29 + 3);
  endfunction

  function automatic logic [31:0] word_at(input int j);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = byte_at(4 * j + k);
    return w;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sready"}, 32'(s_ready), 0);
    chk({tag, "_ws"}, 32'(ws), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_wmode"}, 32'(wmode), 0);
    chk({tag, "_idx"}, {8'h0, wlayer, wn, win}, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_wcount"}, 32'(wcount), 0);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic run_load(input bit toggle, input int wf_delay, input bit noise,
                          input int abort_at, input bit bad_sum);
    int bi, nwr, ndone, wfc, post;
    bit finished;
    logic [7:0] sum;
    int total;
    total = NBYTES;
`ifdef CHECKSUM_EN
    total = NBYTES + 1;
`endif
    bi = 0; nwr = 0; ndone = 0; wfc = 0; post = 0; finished = 0; sum = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    chk("err_clr_on_start", 32'(err), 0);
    chk("wcount_clr_on_start", 32'(wcount), 0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      wf = 1'b0; start = 1'b0; s_valid = 1'b0;
      if (ws) begin
        chk("ws_single", 32'(wfc), 0);
        chk("wlayer", 32'(wlayer), 32'(nwr / (MN * MI)));
        chk("wn", 32'(wn), 32'((nwr / MI) % MN));
        chk("win", 32'(win), 32'(nwr % MI));
        chk("wmode", 32'(wmode), 1);
        chk("wdata", wdata, word_at(nwr));
        wfc = wf_delay;
        nwr++;
      end else if (wfc > 0) begin
        wfc--;
        if (wfc == 0) wf = 1'b1;
      end
      if (done) ndone++;
      if (ndone > 0) begin
        post++;
        if (post > 3) begin finished = 1; break; end
      end
      if (abort_at > 0 && int'(wcount) == abort_at) begin finished = 1; break; end
      if (bi < total && (!toggle || (cyc % 2 == 0))) begin
        s_valid = 1'b1;
        if (bi < NBYTES) s_data = byte_at(bi);
        else             s_data = (8'd0 - sum) + (bad_sum ? 8'd1 : 8'd0);
      end
      if (s_valid && s_ready) begin
        if (bi < NBYTES) sum = sum + s_data;
        bi++;
      end
      if (noise && busy && (cyc % 7 == 3)) start = 1'b1;
      if (noise && s_ready && wfc == 0 && (cyc % 5 == 1)) wf = 1'b1;
      @(negedge clk);
    end
    wf = 1'b0; start = 1'b0; s_valid = 1'b0;
    chk("load_finished", 32'(finished), 1);
    if (abort_at == 0) begin
      chk("write_count", 32'(nwr), NW);
      chk("done_pulses", 32'(ndone), 1);
      chk("wcount_end", 32'(wcount), NW);
      chk("bytes_taken", 32'(bi), 32'(total));
      chk("busy_end", 32'(busy), 0);
`ifdef CHECKSUM_EN
      chk("err_end", 32'(err), 32'(bad_sum));
`else
      chk("err_end", 32'(err), 0);
`endif
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; wf = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    s_valid = 1'b1; s_data = 8'hAA;
    @(negedge clk);
    chk("idle_sready", 32'(s_ready), 0);
    chk("idle_busy", 32'(busy), 0);
    s_valid = 1'b0;

    run_load(0, 2, 0, 0, 0);
    run_load(1, 20, 1, 0, 0);
    run_load(0, 2, 0, 5, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midload_rst");
    rst = 1'b0;
    @(negedge clk);
    run_load(0, 2, 0, 0, 0);
`ifdef CHECKSUM_EN
    run_load(0, 3, 0, 0, 1);
    run_load(0, 2, 0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
